mastermind_board_renderer: RTL and testbench
============================================

Name: mastermind_board_renderer

Overview:
- Pipelined, parametrised VGA renderer for the Mastermind board.
- Draws a ROWS×COLS grid of colour pegs and a per-row feedback strip (exact/partial counts). Highlights the active input row and blinks the cursor slot.
- Snapshots board state once per frame so a frame never tears.
- Sits between display_controller (bright/hCount/vCount) and the VGA DAC pins. The game FSM supplies the board state.

Parameters:
- COLS, 4, pegs per row (1..8)
- ROWS, 6, guess rows (1..8)
- CBITS, 3, bits per colour code
- SLOT, 48, peg cell width/height in px
- MARGIN, 16, gap between cells in px
- RADIUS, 16, peg radius in px (RADIUS*2 < SLOT)
- X0, 300, grid left edge in px
- Y0, 50, grid top edge in px
- FB_GAP, 16, gap in px between the last grid column and the feedback strip
- FB_SLOT, 12, feedback mini-peg cell size in px; mini-peg radius = FB_SLOT/2-2
- BLINK_FRAMES, 30, frames per cursor blink half-period

Ports:
- clk  in  1  pixel clock (~25 MHz)
- rst  in  1  synchronous, active-high reset
- bright  in  1  active-video flag
- hCount  in  10  pixel X
- vCount  in  10  pixel Y
- matrix_flat  in  ROWS*COLS*CBITS  colour codes; row r col c at [(r*COLS+c)*CBITS +: CBITS]
- fb_flat  in  ROWS*2*FBW  per-row {partial,exact} counts, FBW=$clog2(COLS+1); row r exact at [r*2*FBW +: FBW], partial at [r*2*FBW+FBW +: FBW]
- guess_num  in  3  active row index
- cursor_col  in  3  active column within the active row
- q_Input  in  1  high while the game is in its INPUT state
- vgaR  out  4  red
- vgaG  out  4  green
- vgaB  out  4  blue

Behaviour:
- Reset: vgaR/G/B=0, snapshot registers=0, blink counter=0, blink phase=0 (border visible), all pipeline valid bits=0.
- Snapshot: on the cycle with hCount==0 && vCount==0, register matrix_flat, fb_flat, guess_num, cursor_col and q_Input. Rendering uses only the snapshot. Input changes become visible from the next frame.
- Blink: the counter increments on each snapshot cycle. When it reaches BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
- Pipeline, fixed latency 2 clocks. A pixel presented at cycle N drives the DAC at N+2.
  - Stage 1 registers: region (grid / feedback / none), row, col, dx, dy, bright.
  - Stage 2 registers: the final colour.
  - Division is replaced by running cell counters or comparators; no combinational divider.
- bright low at stage 2 -> output 0.
- Grid cell (row,col), cell origin X0+col*(SLOT+MARGIN), Y0+row*(SLOT+MARGIN):
  - Inside the peg circle ((dx-SLOT/2)^2+(dy-SLOT/2)^2 <= RADIUS^2), colour map by code: 1=00F, 2=0F0, 3=0FF, 4=F00, 5=FF0, 6=F0F, 7=FFF, 0=888.
  - Row border (2 px): white FFF when row==guess_num && q_Input.
  - Cursor cell (also col==cursor_col): border is FF0 when blink phase=0 and absent when phase=1. The cursor rule overrides the row-border rule.
  - Everything else: 000.
- Feedback strip for row r:
  - Starts at x = X0+COLS*(SLOT+MARGIN)-MARGIN+FB_GAP, y = row origin + (SLOT-FB_SLOT)/2, height FB_SLOT, COLS mini-cells wide.
  - Mini-peg k: FFF if k<exact; F80 if exact<=k<exact+partial; 333 otherwise.
  - Counts > COLS are saturated to COLS; exact+partial > COLS is clipped at COLS pegs.
- Out-of-range snapshot values: guess_num>=ROWS means no highlight; cursor_col>=COLS means no cursor border.
- The colour code for CBITS>3 uses the low 3 bits.
- Reset asserted mid-frame: outputs are 0 on the next edge, and the snapshot is held at 0 until the next frame start after release.

Test Plan:
- Reset, then hold bright=1 at (hCount,vCount)=(324,74), the centre of cell (0,0), with code 4 loaded before frame start -> vgaR/G/B=F/0/0 exactly 2 clocks after the pixel; 000 while reset is asserted.
- Change matrix_flat mid-frame (cell (0,0) code 4->2) -> the remaining pixels of that frame stay F00; the next frame's centre pixel is 0F0.
- guess_num=2, cursor_col=1, q_Input=1; sample pixel (364+1,178+1) across frames -> FF0 for 30 frames, 000 for 30 frames, repeating. Pixel (300,178) is FFF every frame.
- Row 0 exact=2, partial=1 -> the four mini-peg centres read FFF, FFF, F80, 333. Forcing exact=5 -> all four read FFF.
- bright=0 anywhere, and pixel (0,0) outside the grid -> output 000. A gap pixel (348,60) between cells -> 000.
- guess_num=7, q_Input=1 -> no white or yellow border anywhere in the frame.

Source files
------------

// File: rtl/mastermind_board_renderer_if.sv
// Mastermind renderer bus: raster position in, board state in, VGA colour out.
// Master is the display/game side, slave is the renderer.
interface mastermind_board_renderer_if #(
  parameter int ROWS  = 6,
  parameter int COLS  = 4,
  parameter int CBITS = 3
);
  localparam int FBW = $clog2(COLS + 1);

  logic                        bright;
  logic [9:0]                  hCount;
  logic [9:0]                  vCount;
  logic [ROWS*COLS*CBITS-1:0]  matrix_flat;
  logic [ROWS*2*FBW-1:0]       fb_flat;
  logic [2:0]                  guess_num;
  logic [2:0]                  cursor_col;
  logic                        q_Input;
  logic [3:0]                  vgaR;
  logic [3:0]                  vgaG;
  logic [3:0]                  vgaB;

  modport master (
    output bright, hCount, vCount,
    output matrix_flat, fb_flat,
    output guess_num, cursor_col, q_Input,
    input  vgaR, vgaG, vgaB
  );

  modport slave (
    input  bright, hCount, vCount,
    input  matrix_flat, fb_flat,
    input  guess_num, cursor_col, q_Input,
    output vgaR, vgaG, vgaB
  );
endinterface

// File: rtl/mastermind_board_renderer.sv
// Two-stage VGA renderer for the Mastermind board: peg grid, feedback strip,
// active-row highlight and blinking cursor, from a per-frame board snapshot.
module mastermind_board_renderer #(
  parameter int COLS         = 4,
  parameter int ROWS         = 6,
  parameter int CBITS        = 3,
  parameter int SLOT         = 48,
  parameter int MARGIN       = 16,
  parameter int RADIUS       = 16,
  parameter int X0           = 300,
  parameter int Y0           = 50,
  parameter int FB_GAP       = 16,
  parameter int FB_SLOT      = 12,
  parameter int BLINK_FRAMES = 30
) (
  input logic clk,
  input logic rst,
  mastermind_board_renderer_if.slave bus
);
  localparam int FBW = $clog2(COLS + 1);
  localparam int P   = SLOT + MARGIN;
  localparam int FBX = X0 + COLS * P - MARGIN + FB_GAP;
  localparam int FBY = (SLOT - FB_SLOT) / 2;
  localparam int FR  = FB_SLOT / 2 - 2;
  localparam int DW  = $clog2(SLOT + 1);
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    RG_NONE,
    RG_GRID,
    RG_FB
  } region_t;

  logic [ROWS*COLS*CBITS-1:0] snap_m;
  logic [ROWS*2*FBW-1:0]      snap_fb;
  logic [2:0]                 snap_g;
  logic [2:0]                 snap_c;
  logic                       snap_q;
  logic [BCW-1:0]             blink_cnt;
  logic                       blink_ph;
  logic                       frame_start;

  region_t       reg_n, s1_reg;
  logic [2:0]    row_n, col_n, s1_row, s1_col;
  logic [DW-1:0] dx_n, dy_n, s1_dx, s1_dy;
  logic          s1_bright;
  logic [11:0]   rgb_n, rgb_q;

  assign frame_start = (bus.hCount == 10'd0) && (bus.vCount == 10'd0);

  function automatic logic [11:0] cmap(input logic [2:0] code);
    unique case (code)
      3'd1:    cmap = 12'h00F;
      3'd2:    cmap = 12'h0F0;
      3'd3:    cmap = 12'h0FF;
      3'd4:    cmap = 12'hF00;
      3'd5:    cmap = 12'hFF0;
      3'd6:    cmap = 12'hF0F;
      3'd7:    cmap = 12'hFFF;
      default: cmap = 12'h888;
    endcase
  endfunction

  // Latch board state and advance the blink timer at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_m    <= '0;
      snap_fb   <= '0;
      snap_g    <= '0;
      snap_c    <= '0;
      snap_q    <= 1'b0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame_start) begin
      snap_m  <= bus.matrix_flat;
      snap_fb <= bus.fb_flat;
      snap_g  <= bus.guess_num;
      snap_c  <= bus.cursor_col;
      snap_q  <= bus.q_Input;
      if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Locate the pixel in a grid cell or feedback mini-cell by comparators.
  always_comb begin
    int hi, vi;
    logic gc_ok, gr_ok, fc_ok, fr_ok;
    logic [2:0] gc, gr, fk, fr;
    logic [DW-1:0] gdx, gdy, fdx, fdy;
    hi = int'(bus.hCount);
    vi = int'(bus.vCount);
    gc_ok = 1'b0;
    gr_ok = 1'b0;
    fc_ok = 1'b0;
    fr_ok = 1'b0;
    gc = '0;
    gr = '0;
    fk = '0;
    fr = '0;
    gdx = '0;
    gdy = '0;
    fdx = '0;
    fdy = '0;
    reg_n = RG_NONE;
    row_n = '0;
    col_n = '0;
    dx_n = '0;
    dy_n = '0;
    for (int c = 0; c < COLS; c++) begin
      if (hi >= X0 + c * P && hi < X0 + c * P + SLOT) begin
        gc_ok = 1'b1;
        gc = 3'(c);
        gdx = DW'(hi - X0 - c * P);
      end
      if (hi >= FBX + c * FB_SLOT && hi < FBX + (c + 1) * FB_SLOT) begin
        fc_ok = 1'b1;
        fk = 3'(c);
        fdx = DW'(hi - FBX - c * FB_SLOT);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (vi >= Y0 + r * P && vi < Y0 + r * P + SLOT) begin
        gr_ok = 1'b1;
        gr = 3'(r);
        gdy = DW'(vi - Y0 - r * P);
      end
      if (vi >= Y0 + r * P + FBY && vi < Y0 + r * P + FBY + FB_SLOT) begin
        fr_ok = 1'b1;
        fr = 3'(r);
        fdy = DW'(vi - Y0 - r * P - FBY);
      end
    end
    if (gc_ok && gr_ok) begin
      reg_n = RG_GRID;
      row_n = gr;
      col_n = gc;
      dx_n = gdx;
      dy_n = gdy;
    end else if (fc_ok && fr_ok) begin
      reg_n = RG_FB;
      row_n = fr;
      col_n = fk;
      dx_n = fdx;
      dy_n = fdy;
    end
  end

  // Stage 1: register pixel location.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg    <= RG_NONE;
      s1_row    <= '0;
      s1_col    <= '0;
      s1_dx     <= '0;
      s1_dy     <= '0;
      s1_bright <= 1'b0;
    end else begin
      s1_reg    <= reg_n;
      s1_row    <= row_n;
      s1_col    <= col_n;
      s1_dx     <= dx_n;
      s1_dy     <= dy_n;
      s1_bright <= bus.bright;
    end
  end

  // Resolve the final colour of the located pixel from the snapshot.
  always_comb begin
    int dxi, dyi, ex, pa, k, base;
    logic hl, cur, border;
    logic [2:0] code;
    dxi = int'(s1_dx);
    dyi = int'(s1_dy);
    k = int'(s1_col);
    base = int'(s1_row) * 2 * FBW;
    code = snap_m[(int'(s1_row) * COLS + k) * CBITS +: 3];
    ex = int'(snap_fb[base +: FBW]);
    pa = int'(snap_fb[base + FBW +: FBW]);
    if (ex > COLS) ex = COLS;
    if (pa > COLS) pa = COLS;
    hl = snap_q && (int'(snap_g) < ROWS) && (snap_g == s1_row);
    cur = hl && (int'(snap_c) < COLS) && (snap_c == s1_col);
    border = (dxi < 2) || (dxi >= SLOT - 2) ||
             (dyi < 2) || (dyi >= SLOT - 2);
    rgb_n = 12'h000;
    unique case (1'b1)
      (s1_reg == RG_GRID): begin
        if ((dxi - SLOT/2) * (dxi - SLOT/2) +
            (dyi - SLOT/2) * (dyi - SLOT/2) <= RADIUS * RADIUS)
          rgb_n = cmap(code);
        else if (border && cur)
          rgb_n = blink_ph ? 12'h000 : 12'hFF0;
        else if (border && hl)
          rgb_n = 12'hFFF;
      end
      (s1_reg == RG_FB): begin
        if ((dxi - FB_SLOT/2) * (dxi - FB_SLOT/2) +
            (dyi - FB_SLOT/2) * (dyi - FB_SLOT/2) <= FR * FR) begin
          if (k < ex)
            rgb_n = 12'hFFF;
          else if (k < ex + pa)
            rgb_n = 12'hF80;
          else
            rgb_n = 12'h333;
        end
      end
      default: rgb_n = 12'h000;
    endcase
  end

  // Stage 2: register the DAC colour, blanked outside active video.
  always_ff @(posedge clk) begin
    if (rst)
      rgb_q <= '0;
    else
      rgb_q <= s1_bright ? rgb_n : 12'h000;
  end

  assign bus.vgaR = rgb_q[11:8];
  assign bus.vgaG = rgb_q[7:4];
  assign bus.vgaB = rgb_q[3:0];
endmodule

// File: tb/tb_mastermind_board_renderer.sv
// Directed bench for the Mastermind renderer: colours, latency, snapshot,
// blink timing, feedback strip and highlight corner cases.
module tb_mastermind_board_renderer;
  localparam int ROWS = 6;
  localparam int COLS = 4;
  localparam int CBITS = 3;
  localparam int FBW = 3;
  localparam int BF = 30;

  logic clk;
  logic rst;
  int checks;
  int errors;
  int bc;
  logic bp;

  mastermind_board_renderer_if #(
    .ROWS(ROWS), .COLS(COLS), .CBITS(CBITS)
  ) bus ();

  mastermind_board_renderer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic tick();
    if (!rst && bus.hCount == 10'd0 && bus.vCount == 10'd0) begin
      if (bc == BF - 1) begin
        bc = 0;
        bp = ~bp;
      end else begin
        bc++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = {bus.vgaR, bus.vgaG, bus.vgaB};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic probe(input int h, input int v, input logic b,
                       input logic [11:0] exp, input string tag);
    bus.hCount = 10'(h);
    bus.vCount = 10'(v);
    bus.bright = b;
    @(posedge clk);
    tick();
    @(posedge clk);
    tick();
    #1;
    check(tag, exp);
  endtask

  task automatic frame();
    bus.hCount = 10'd0;
    bus.vCount = 10'd0;
    @(posedge clk);
    tick();
    #1;
  endtask

  task automatic set_code(input int r, input int c, input logic [2:0] code);
    bus.matrix_flat[(r * COLS + c) * CBITS +: CBITS] = code;
  endtask

  task automatic set_fb(input int r, input logic [2:0] ex,
                        input logic [2:0] pa);
    bus.fb_flat[r * 2 * FBW +: FBW] = ex;
    bus.fb_flat[r * 2 * FBW + FBW +: FBW] = pa;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bc = 0;
    bp = 1'b0;
    rst = 1'b1;
    bus.bright = 1'b1;
    bus.hCount = 10'd324;
    bus.vCount = 10'd74;
    bus.matrix_flat = '0;
    bus.fb_flat = '0;
    bus.guess_num = 3'd0;
    bus.cursor_col = 3'd0;
    bus.q_Input = 1'b0;
    set_code(0, 0, 3'd4);
    set_code(1, 3, 3'd6);
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 12'h000);
    probe(324, 74, 1'b1, 12'h000, "in_reset");
    rst = 1'b0;

    bus.hCount = 10'd0;
    bus.vCount = 10'd0;
    @(posedge clk);
    tick();
    #1;
    bus.hCount = 10'd324;
    bus.vCount = 10'd74;
    @(posedge clk);
    #1;
    check("lat_1clk", 12'h000);
    @(posedge clk);
    #1;
    check("lat_2clk", 12'hF00);

    set_code(0, 0, 3'd2);
    probe(324, 74, 1'b1, 12'hF00, "mid_frame_hold");
    probe(516, 138, 1'b1, 12'hF0F, "code6");
    frame();
    probe(324, 74, 1'b1, 12'h0F0, "next_frame");
    probe(324, 74, 1'b0, 12'h000, "bright_low");
    probe(0, 0, 1'b1, 12'h000, "outside");
    probe(348, 60, 1'b1, 12'h000, "gap");

    set_fb(0, 3'd2, 3'd1);
    frame();
    probe(562, 74, 1'b1, 12'hFFF, "fb_k0");
    probe(574, 74, 1'b1, 12'hFFF, "fb_k1");
    probe(586, 74, 1'b1, 12'hF80, "fb_k2");
    probe(598, 74, 1'b1, 12'h333, "fb_k3");
    probe(556, 68, 1'b1, 12'h000, "fb_corner");
    set_fb(0, 3'd5, 3'd1);
    frame();
    for (int k = 0; k < COLS; k++)
      probe(562 + 12 * k, 74, 1'b1, 12'hFFF, "fb_sat");
    set_fb(0, 3'd1, 3'd5);
    frame();
    probe(562, 74, 1'b1, 12'hFFF, "fb_clip0");
    for (int k = 1; k < COLS; k++)
      probe(562 + 12 * k, 74, 1'b1, 12'hF80, "fb_clip");

    bus.guess_num = 3'd2;
    bus.cursor_col = 3'd1;
    bus.q_Input = 1'b1;
    for (int f = 0; f < 70; f++) begin
      frame();
      probe(365, 179, 1'b1, bp ? 12'h000 : 12'hFF0, "cursor_blink");
      probe(300, 178, 1'b1, 12'hFFF, "row_border");
    end

    bus.cursor_col = 3'd5;
    frame();
    probe(365, 179, 1'b1, 12'hFFF, "cursor_oob");
    bus.q_Input = 1'b0;
    frame();
    probe(300, 178, 1'b1, 12'h000, "no_input");

    bus.guess_num = 3'd7;
    bus.cursor_col = 3'd1;
    bus.q_Input = 1'b1;
    frame();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        probe(300 + 64 * c, 50 + 64 * r, 1'b1, 12'h000, "guess_oob_a");
        probe(347 + 64 * c, 51 + 64 * r, 1'b1, 12'h000, "guess_oob_b");
      end
    end

    bus.hCount = 10'd324;
    bus.vCount = 10'd74;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid", 12'h000);
    rst = 1'b0;
    bc = 0;
    bp = 1'b0;
    probe(324, 74, 1'b1, 12'h888, "snap_zero");
    frame();
    probe(324, 74, 1'b1, 12'h0F0, "snap_reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
